pwm_capture: RTL
================

Name: pwm_capture

Overview:
- PWM decoder: measures the period and high time of an incoming PWM pulse train and recovers the 8-bit duty code that produced it.
- Pairs with the team's 8-bit free-running PWM generator. That generator has a 256-cycle period and drives the output high while counter > duty, so high time = 255 - duty cycles.
- Sits on the receive side of loopback and self-test paths. The input may be asynchronous to clk.

Parameters:
- CW, 12, width of the period and high-time counters; saturation value MAXC = 2^CW-1.
- EXP_PERIOD, 256, expected period in clk cycles, used for the period_ok check and duty recovery.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- pwm_in  input  1  PWM signal, possibly asynchronous
- meas_valid  output  1  one-cycle strobe: a new measurement is presented
- period  output  CW  cycles between the last two rising edges
- high_time  output  CW  cycles pwm_in was high within that period
- period_ok  output  1  period == EXP_PERIOD
- duty  output  8  recovered duty code = EXP_PERIOD-1-high_time, clamped to 0..255; 0 when period_ok=0
- stuck  output  1  no rising edge seen for MAXC cycles
- stuck_level  output  1  synchronized level of pwm_in when stuck was set

Behaviour:
- Reset: every register clears asynchronously. All outputs are 0 and the state is WAIT_EDGE.
- Input path:
  - 2-FF synchronizer s1 -> s2, then a prev register.
  - rise = s2 & ~prev.
  - All counting uses s2.
- State WAIT_EDGE:
  - Counters are held at 0.
  - pcnt still counts toward timeout (see stuck rule).
  - On rise: go to MEASURE, set pcnt=1, set hcnt=1 (s2 is high).
- State MEASURE, each cycle without rise:
  - pcnt += 1, saturating at MAXC.
  - hcnt += s2, saturating at MAXC.
- State MEASURE, cycle with rise:
  - Register period=pcnt, high_time=hcnt, period_ok, and duty.
  - Pulse meas_valid for 1 cycle and clear stuck.
  - Restart with pcnt=1, hcnt=1 and stay in MEASURE.
  - Back-to-back periods lose no cycles.
- Stuck rule:
  - Applies in either state when pcnt reaches MAXC with no rise.
  - Set stuck=1 and stuck_level=s2, go to WAIT_EDGE, clear counters.
  - No meas_valid is issued.
  - Data outputs keep their last values.
  - stuck stays set until the next meas_valid.
- Latency: pin rises before clk edge k -> s1 at k, s2 at k+1 -> meas_valid and data registered at edge k+2.
- Data outputs are stable between strobes.
- The first rise after reset or after stuck only arms the measurement; the first meas_valid comes on the second rise.
- Duty arithmetic:
  - Computed at CW+1 bits, signed.
  - If the result is < 0, duty = 0; if > 255, duty = 255.
  - Only meaningful when period_ok=1; otherwise duty = 0.
- Generator corner cases:
  - duty=0 yields 255 high / 1 low.
  - duty=255 yields a constant-low input, which is reported as stuck=1, stuck_level=0.
  - A constant-high input is reported as stuck=1, stuck_level=1.
- Glitches shorter than one clk may be missed. A one-cycle high pulse is measured as high_time=1.

Decomposition:
- Shared package: state encoding (WAIT_EDGE, MEASURE), MAXC, the EXP_PERIOD default, and the duty-clamp function.
- One natural sub-module: sync2, the 2-FF synchronizer with async active-high reset, reusable elsewhere.
- The rest of the block is a single FSM plus datapath.

Test Plan:
- Generator duty=100 at 256-cycle period -> from the 2nd rise, meas_valid once every 256 cycles; period=256, high_time=155, period_ok=1, duty=100.
- Generator duty=0, then duty=254 -> high_time=255, duty=0; then high_time=1, duty=254; stuck stays 0.
- Constant low for 5000 cycles -> stuck=1 and stuck_level=0 after 4095 cycles; no meas_valid. Then restart with duty=10 -> the second rise gives meas_valid with duty=10 and stuck=0.
- Period 300, high 120 -> period=300, high_time=120, period_ok=0, duty=0.
- Assert rst mid-MEASURE -> all outputs 0 immediately (asynchronous). After release, the first rise gives no strobe and the second rise gives a correct measurement.
- Pin rise placed just before clk edge k -> meas_valid high exactly after edge k+2. Back-to-back periods produce strobes exactly period cycles apart.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block: FSM states,
// default sizing and the duty-code clamp.
package pwm_capture_pkg;

  typedef enum logic {
    WAIT_EDGE,
    MEASURE
  } state_t;

  localparam int DEF_CW         = 12;
  localparam int DEF_EXP_PERIOD = 256;
  localparam int DEF_MAXC       = (1 << DEF_CW) - 1;

  // Clamp a signed duty estimate into the 8-bit code range.
  function automatic logic [7:0] clamp_duty(input int v);
    if (v < 0)
      return '0;
    else if (v > 255)
      return '1;
    else
      return 8'(v);
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// PWM input plus measurement results; master is the capture block,
// slave is whoever drives the pin and consumes the results.
interface pwm_capture_if
  import pwm_capture_pkg::*;
#(
  parameter int CW = DEF_CW
);

  logic          pwm_in;
  logic          meas_valid;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          period_ok;
  logic [7:0]    duty;
  logic          stuck;
  logic          stuck_level;

  modport master (
    input  pwm_in,
    output meas_valid, period, high_time, period_ok, duty, stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  meas_valid, period, high_time, period_ok, duty, stuck, stuck_level
  );

endinterface

// File: rtl/pwm_capture_sync2.sv
// Two-flop synchronizer for a single asynchronous bit, async active-high reset.
module pwm_capture_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures period and high time between rising edges and
// recovers the generator duty code; flags a stuck input after MAXC idle cycles.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CW         = DEF_CW,
  parameter int EXP_PERIOD = DEF_EXP_PERIOD
) (
  input  logic          clk,
  input  logic          rst,
  pwm_capture_if.master bus
);

  localparam logic [CW-1:0] MAXC = '1;

  state_t        state;
  logic          s2;
  logic          prev;
  logic          rise;
  logic          timeout;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] hcnt;
  logic signed [CW:0] duty_diff;

  logic          meas_valid_q;
  logic [CW-1:0] period_q;
  logic [CW-1:0] high_time_q;
  logic          period_ok_q;
  logic [7:0]    duty_q;
  logic          stuck_q;
  logic          stuck_level_q;

  pwm_capture_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pwm_in),
    .q   (s2)
  );

  assign rise      = s2 & ~prev;
  assign timeout   = ~rise && (pcnt == MAXC);
  assign duty_diff = $signed((CW+1)'(EXP_PERIOD - 1)) - $signed({1'b0, hcnt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= WAIT_EDGE;
      prev          <= 1'b0;
      pcnt          <= '0;
      hcnt          <= '0;
      meas_valid_q  <= 1'b0;
      period_q      <= '0;
      high_time_q   <= '0;
      period_ok_q   <= 1'b0;
      duty_q        <= '0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      prev         <= s2;
      meas_valid_q <= 1'b0;
      // Timeout takes priority in both states; results are left untouched.
      if (timeout) begin
        state         <= WAIT_EDGE;
        pcnt          <= '0;
        hcnt          <= '0;
        stuck_q       <= 1'b1;
        stuck_level_q <= s2;
      end else begin
        case (state)
          WAIT_EDGE: begin
            if (rise) begin
              state <= MEASURE;
              pcnt  <= CW'(1);
              hcnt  <= CW'(1);
            end else begin
              pcnt <= pcnt + 1'b1;
              hcnt <= '0;
            end
          end
          MEASURE: begin
            if (rise) begin
              // The rise cycle is the first cycle of the next period.
              period_q     <= pcnt;
              high_time_q  <= hcnt;
              period_ok_q  <= (pcnt == CW'(EXP_PERIOD));
              duty_q       <= (pcnt == CW'(EXP_PERIOD)) ? clamp_duty(int'(duty_diff)) : '0;
              meas_valid_q <= 1'b1;
              stuck_q      <= 1'b0;
              pcnt         <= CW'(1);
              hcnt         <= CW'(1);
            end else begin
              pcnt <= pcnt + 1'b1;
              if (s2 && (hcnt != MAXC))
                hcnt <= hcnt + 1'b1;
            end
          end
          default: state <= WAIT_EDGE;
        endcase
      end
    end
  end

  assign bus.meas_valid  = meas_valid_q;
  assign bus.period      = period_q;
  assign bus.high_time   = high_time_q;
  assign bus.period_ok   = period_ok_q;
  assign bus.duty        = duty_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;

endmodule
